// File: rtl/ram_initiator.sv
// rtl/ram_initiator.sv - command-driven write/read/burst controller for the synchronous RAM
// Every RAM-side and response output is registered; cmd_ready/busy decode the state.
module ram_initiator #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH),
  parameter int LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [MEM_WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0]     cmd_len,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 cmd_done,
  output logic                 busy,
  output logic [MEM_WIDTH-1:0] ram_din,
  output logic [ADDR_SIZE-1:0] ram_addr_wr,
  output logic [ADDR_SIZE-1:0] ram_addr_rd,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  input  logic [MEM_WIDTH-1:0] ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_ISSUE, S_RD_CAPT, S_RESP} state_t;

  localparam logic [1:0]           OP_WRITE  = 2'b00;
  localparam logic [1:0]           OP_FILL   = 2'b11;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [LEN_W:0]       ONE_BEAT  = (LEN_W+1)'(1);

  state_t                 r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0]   r_addr, w_addr_nxt;
  logic [MEM_WIDTH-1:0]   r_data, w_data_nxt;
  logic [LEN_W:0]         r_beats, w_beats_nxt;
  logic                   r_wr_en, w_wr_en_nxt;
  logic                   r_rd_en, w_rd_en_nxt;
  logic [ADDR_SIZE-1:0]   r_addr_wr, w_addr_wr_nxt;
  logic [ADDR_SIZE-1:0]   r_addr_rd, w_addr_rd_nxt;
  logic [MEM_WIDTH-1:0]   r_din, w_din_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic [MEM_WIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                   r_done, w_done_nxt;
  logic [ADDR_SIZE-1:0]   w_addr_inc;
  logic                   w_last_beat;

  // Explicit wrap so non-power-of-2 depths never address past the last word.
  assign w_addr_inc  = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_SIZE'(1);
  assign w_last_beat = (r_beats == ONE_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_beats     <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr_wr   <= '0;
      r_addr_rd   <= '0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_beats     <= w_beats_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_addr_wr   <= w_addr_wr_nxt;
      r_addr_rd   <= w_addr_rd_nxt;
      r_din       <= w_din_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_beats_nxt     = r_beats;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_addr_wr_nxt   = r_addr_wr;
    w_addr_rd_nxt   = r_addr_rd;
    w_din_nxt       = r_din;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_addr_nxt  = cmd_addr;
          w_data_nxt  = cmd_data;
          w_beats_nxt = cmd_op[1] ? ({1'b0, cmd_len} + ONE_BEAT) : ONE_BEAT;
          if (cmd_op == OP_WRITE || cmd_op == OP_FILL) begin
            w_state_nxt   = S_WR;
            w_wr_en_nxt   = 1'b1;
            w_addr_wr_nxt = cmd_addr;
            w_din_nxt     = cmd_data;
          end else begin
            w_state_nxt   = S_RD_ISSUE;
            w_rd_en_nxt   = 1'b1;
            w_addr_rd_nxt = cmd_addr;
          end
        end
      end
      S_WR: begin
        if (w_last_beat) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_beats_nxt   = r_beats - ONE_BEAT;
          w_addr_nxt    = w_addr_inc;
          w_addr_wr_nxt = w_addr_inc;
          w_din_nxt     = r_data;
          w_wr_en_nxt   = 1'b1;
        end
      end
      S_RD_ISSUE: w_state_nxt = S_RD_CAPT;
      S_RD_CAPT: begin
        w_rsp_data_nxt  = ram_dout;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          if (w_last_beat) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_beats_nxt   = r_beats - ONE_BEAT;
            w_addr_nxt    = w_addr_inc;
            w_addr_rd_nxt = w_addr_inc;
            w_rd_en_nxt   = 1'b1;
            w_state_nxt   = S_RD_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign cmd_done    = r_done;
  assign ram_din     = r_din;
  assign ram_addr_wr = r_addr_wr;
  assign ram_addr_rd = r_addr_rd;
  assign ram_wr_en   = r_wr_en;
  assign ram_rd_en   = r_rd_en;

endmodule

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
- Command-driven controller that drives the write/read port of the team's parameterized synchronous RAM (din, addr_wr, addr_rd, wr_en, rd_en, registered dout).
- Accepts single-word and burst commands on a valid/ready interface and issues the RAM strobes.
- Returns read data on a valid/ready response channel.
- Sits between a bus/serial front-end and the RAM.

Parameters:
- MEM_WIDTH, 8, data width; matches the RAM.
- MEM_DEPTH, 256, RAM word count; any value ≥2.
- ADDR_SIZE, $clog2(MEM_DEPTH), address width.
- LEN_W, 8, burst length field width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle; command accepted when cmd_valid & cmd_ready at posedge.
- cmd_op  in  2  00 WRITE, 01 READ, 10 BURST_READ, 11 FILL.
- cmd_addr  in  ADDR_SIZE  start address.
- cmd_data  in  MEM_WIDTH  write/fill data.
- cmd_len  in  LEN_W  beats = cmd_len+1 (bursts only; ignored for WRITE/READ).
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts rsp_data.
- rsp_data  out  MEM_WIDTH  read data.
- cmd_done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state ≠ IDLE.
- ram_din  out  MEM_WIDTH  to RAM din.
- ram_addr_wr  out  ADDR_SIZE  to RAM addr_wr.
- ram_addr_rd  out  ADDR_SIZE  to RAM addr_rd.
- ram_wr_en  out  1  to RAM wr_en.
- ram_rd_en  out  1  to RAM rd_en.
- ram_dout  in  MEM_WIDTH  from RAM dout; valid the cycle after ram_rd_en.

Behaviour:
- Reset:
  - rst high forces IDLE immediately, including mid-command; the in-flight command is abandoned with no cmd_done.
  - All outputs reset to 0, except cmd_ready, which reads 1 once in IDLE.
- All RAM-side outputs and rsp_* are registered.
- FSM states: IDLE, WR, RD_ISSUE, RD_CAPT, RESP.
- IDLE:
  - cmd_ready=1.
  - On acceptance, latch addr, data and beat count (WRITE/READ: 1 beat).
  - WRITE/FILL go to WR; READ/BURST_READ go to RD_ISSUE.
- WR:
  - ram_wr_en=1, ram_addr_wr=current addr, ram_din=latched data, for one cycle per beat on consecutive cycles.
  - After the last beat, go to IDLE with cmd_done=1 in that first IDLE cycle.
  - WRITE accepted at edge T: wr_en high in cycle T+1, cmd_done in T+2.
- RD_ISSUE:
  - ram_rd_en=1, ram_addr_rd=current addr, for one cycle; then RD_CAPT.
- RD_CAPT:
  - At end of cycle, rsp_data<=ram_dout and rsp_valid<=1; then RESP.
  - READ accepted at edge T: rd_en in T+1, rsp_valid in T+3.
- RESP:
  - rsp_valid and rsp_data held stable until rsp_ready sampled high.
  - On handshake: rsp_valid<=0; if beats remain, advance addr and go to RD_ISSUE; else go to IDLE with cmd_done pulse.
  - rsp_ready may be held high continuously: one beat per 3 cycles.
- Address advance: addr = (addr==MEM_DEPTH-1) ? 0 : addr+1. Explicit wrap, also correct for non-power-of-2 depth.
- Beat counter: LEN_W+1 bits; max burst 2^LEN_W beats; may wrap the full RAM repeatedly.
- Commands while busy: cmd_ready=0; cmd_valid ignored; no queuing.
- ram_wr_en and ram_rd_en are never high in the same cycle.
- rsp_ready outside RESP is ignored.
- Unused RAM-side address/data outputs hold their last value.

Test Plan:
- WRITE addr 0x10 data 0xA5, then READ 0x10 with rsp_ready=1 -> wr_en one cycle at 0x10/0xA5; rsp_data=0xA5 three cycles after READ acceptance; two cmd_done pulses.
- FILL addr 254 len 3 data 0x3C (depth 256) -> wr_en on 4 consecutive cycles at 254, 255, 0, 1; cmd_done one cycle later; BURST_READ 254 len 3 returns 0x3C ×4.
- BURST_READ len 2 with rsp_ready low 5 cycles per beat -> rsp_valid/rsp_data stable while stalled; exactly 3 handshakes; no extra rd_en; then cmd_done.
- cmd_valid held high with a new op during a burst -> cmd_ready=0, second command accepted only in first IDLE cycle (same cycle as cmd_done).
- rst asserted mid-FILL len 10 after 4 beats -> outputs 0 immediately; no cmd_done; only 4 locations written; next command accepted normally.
- MEM_DEPTH=10 FILL addr 8 len 3 -> writes 8, 9, 0, 1.
